// File: rtl/loss_pkg.sv
// Shared widths and FSM state encoding for the batch loss sequencer.
package loss_pkg;

  localparam int TGT_W_DEF  = 4;
  localparam int PRED_W_DEF = 21;
  localparam int LOSS_W_DEF = 42;
  localparam int CNT_W_DEF  = 8;
  localparam int ACC_W_DEF  = 48;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_CALC = 3'd2,
    ST_ACC  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/loss_sat_accum.sv
// Saturating batch accumulator: clear, add a zero-extended addend, sticky saturation flag.
module loss_sat_accum #(
  parameter int LOSS_W = 42,
  parameter int ACC_W  = 48
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              add_en_i,
  input  logic [LOSS_W-1:0] addend_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              sat_o
);

  logic [ACC_W-1:0] sum_q;
  logic             sat_q;
  logic [ACC_W:0]   sum_d;

  // One spare bit catches the carry-out that signals saturation.
  assign sum_d = {1'b0, sum_q} + {{(ACC_W + 1 - LOSS_W){1'b0}}, addend_i};

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sum_q <= '0;
      sat_q <= 1'b0;
    end else if (clear_i) begin
      sum_q <= '0;
      sat_q <= 1'b0;
    end else if (add_en_i) begin
      if (sum_d[ACC_W]) begin
        sum_q <= '1;
        sat_q <= 1'b1;
      end else begin
        sum_q <= sum_d[ACC_W-1:0];
      end
    end
  end

  assign sum_o = sum_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/loss_batch_ctrl.sv
// Batch sequencer for the squared-error loss unit: accepts samples, issues them one at a
// time, accumulates the returned losses and reports a saturating batch total.
module loss_batch_ctrl
  import loss_pkg::*;
#(
  parameter int TGT_W  = TGT_W_DEF,
  parameter int PRED_W = PRED_W_DEF,
  parameter int LOSS_W = LOSS_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [CNT_W-1:0]  batch_len_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [TGT_W-1:0]  s_target_i,
  input  logic [PRED_W-1:0] s_pred_i,
  output logic              calc_en_o,
  output logic [TGT_W-1:0]  calc_target_o,
  output logic [PRED_W-1:0] calc_pred_o,
  input  logic [LOSS_W-1:0] calc_loss_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ACC_W-1:0]  loss_sum_o,
  output logic              sat_o
);

  state_t            state_q;
  logic [CNT_W-1:0]  remaining_q;
  logic [TGT_W-1:0]  calc_target_q;
  logic [PRED_W-1:0] calc_pred_q;
  logic [ACC_W-1:0]  loss_sum_q;
  logic [ACC_W-1:0]  acc_sum;
  logic              acc_sat;
  logic              start_go;
  logic              abort_go;

  assign start_go = (state_q == ST_IDLE) && start_i;
  assign abort_go = (state_q != ST_IDLE) && abort_i;

  // Clearing on abort also discards any loss still in flight from the unit.
  loss_sat_accum #(
    .LOSS_W (LOSS_W),
    .ACC_W  (ACC_W)
  ) u_accum (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (start_go | abort_go),
    .add_en_i (state_q == ST_ACC),
    .addend_i (calc_loss_i),
    .sum_o    (acc_sum),
    .sat_o    (acc_sat)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q       <= ST_IDLE;
      remaining_q   <= '0;
      calc_target_q <= '0;
      calc_pred_q   <= '0;
      loss_sum_q    <= '0;
    end else if (abort_go) begin
      state_q    <= ST_IDLE;
      loss_sum_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            remaining_q <= batch_len_i;
            loss_sum_q  <= '0;
            state_q     <= (batch_len_i == '0) ? ST_DONE : ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (s_valid_i) begin
            calc_target_q <= s_target_i;
            calc_pred_q   <= s_pred_i;
            state_q       <= ST_CALC;
          end
        end
        ST_CALC: state_q <= ST_ACC;
        ST_ACC: begin
          remaining_q <= remaining_q - CNT_W'(1);
          state_q     <= (remaining_q == CNT_W'(1)) ? ST_DONE : ST_LOAD;
        end
        ST_DONE: begin
          loss_sum_q <= acc_sum;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_ready_o     = (state_q == ST_LOAD);
  assign calc_en_o     = (state_q == ST_CALC);
  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = (state_q == ST_DONE);
  assign calc_target_o = calc_target_q;
  assign calc_pred_o   = calc_pred_q;
  // The total is presented during the done cycle itself and held afterwards.
  assign loss_sum_o    = (state_q == ST_DONE) ? acc_sum : loss_sum_q;
  assign sat_o         = acc_sat;

endmodule
